// File: rtl/regs_dp_be_s_if.sv
// Bus bundle for the dual-read, byte-enabled DFF register array.
// The master drives requests; the slave (the memory) drives status and read data.
interface regs_dp_be_s_if #(
    parameter int ADDR   = 6,
    parameter int W_SIZE = 32
);
    logic                  dffs_clr;
    logic                  dffs_busy;
    logic                  dffs_wen;
    logic [ADDR-1:0]       dffs_waddr;
    logic [W_SIZE/8-1:0]   dffs_wbe;
    logic [W_SIZE-1:0]     dffs_wdata;
    logic                  dffs_werr;
    logic                  dffs_ren_a;
    logic [ADDR-1:0]       dffs_raddr_a;
    logic [W_SIZE-1:0]     dffs_rdata_a;
    logic                  dffs_rvld_a;
    logic                  dffs_ren_b;
    logic [ADDR-1:0]       dffs_raddr_b;
    logic [W_SIZE-1:0]     dffs_rdata_b;
    logic                  dffs_rvld_b;

    modport master (
        output dffs_clr, dffs_wen, dffs_waddr, dffs_wbe, dffs_wdata,
        output dffs_ren_a, dffs_raddr_a, dffs_ren_b, dffs_raddr_b,
        input  dffs_busy, dffs_werr,
        input  dffs_rdata_a, dffs_rvld_a, dffs_rdata_b, dffs_rvld_b
    );

    modport slave (
        input  dffs_clr, dffs_wen, dffs_waddr, dffs_wbe, dffs_wdata,
        input  dffs_ren_a, dffs_raddr_a, dffs_ren_b, dffs_raddr_b,
        output dffs_busy, dffs_werr,
        output dffs_rdata_a, dffs_rvld_a, dffs_rdata_b, dffs_rvld_b
    );
endinterface

// File: rtl/regs_dp_be_s.sv
// DFF register-array memory: one byte-enabled write port, two registered
// read ports with valid strobes, selectable read-during-write policy and a
// clear sequencer that sweeps CLR_VAL into every entry, one per cycle.
module regs_dp_be_s #(
    parameter int                ADDR    = 6,
    parameter int                WORDS   = 64,
    parameter int                W_SIZE  = 32,
    parameter int                BYPASS  = 1,
    parameter logic [W_SIZE-1:0] CLR_VAL = '0
) (
    input  logic          dffs_clk,
    input  logic          dffs_rst,
    regs_dp_be_s_if.slave dffs_bus
);
    localparam int              NB      = W_SIZE / 8;
    localparam logic [ADDR:0]   WORDS_L = (ADDR + 1)'(WORDS);
    localparam logic [ADDR-1:0] LAST    = ADDR'(WORDS - 1);
    localparam bit              WF      = (BYPASS != 0);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state_reg, state_next;
    logic [ADDR-1:0] cnt_reg, cnt_next;
    logic            busy;
    logic            waddr_ok;
    logic            user_wr;
    logic            werr_reg;

    // Single effective write port shared by user writes and the sweep
    logic              eff_we;
    logic [ADDR-1:0]   eff_addr;
    logic [NB-1:0]     eff_be;
    logic [W_SIZE-1:0] eff_data;

    logic [W_SIZE-1:0] mem_word [WORDS];

    // Replace the enabled bytes of old_w with the matching bytes of new_w
    function automatic logic [W_SIZE-1:0] merge_be(
        input logic [W_SIZE-1:0] old_w,
        input logic [NB-1:0]     be,
        input logic [W_SIZE-1:0] new_w
    );
        logic [W_SIZE-1:0] res;
        res = old_w;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

    // Clear sequencer state and sweep counter
    always_ff @(posedge dffs_clk or posedge dffs_rst) begin
        if (dffs_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Sweep sequencing: start on clr in IDLE, step one entry per cycle, stop after the last
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (dffs_bus.dffs_clr) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt_reg == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy     = (state_reg == CLEAR);
    assign waddr_ok = ({1'b0, dffs_bus.dffs_waddr} < WORDS_L);
    assign user_wr  = dffs_bus.dffs_wen && !busy && waddr_ok;

    // Select the write source: the sweep owns the array while busy
    always_comb begin
        eff_we   = 1'b0;
        eff_addr = dffs_bus.dffs_waddr;
        eff_be   = dffs_bus.dffs_wbe;
        eff_data = dffs_bus.dffs_wdata;
        if (busy) begin
            eff_we   = 1'b1;
            eff_addr = cnt_reg;
            eff_be   = '1;
            eff_data = CLR_VAL;
        end else if (user_wr) begin
            eff_we = 1'b1;
        end
    end

    // Rejected write (during sweep or out of range) flagged for one cycle
    always_ff @(posedge dffs_clk or posedge dffs_rst) begin
        if (dffs_rst) werr_reg <= 1'b0;
        else          werr_reg <= dffs_bus.dffs_wen && (busy || !waddr_ok);
    end

    genvar gi;

    // One storage word per entry, updated byte-wise by the effective write port
    for (gi = 0; gi < WORDS; gi++) begin : g_entry
        logic [W_SIZE-1:0] word_reg;

        // Entry update
        always_ff @(posedge dffs_clk or posedge dffs_rst) begin
            if (dffs_rst)
                word_reg <= '0;
            else if (eff_we && (eff_addr == ADDR'(gi)))
                word_reg <= merge_be(word_reg, eff_be, eff_data);
        end

        assign mem_word[gi] = word_reg;
    end

    // Read ports as arrays so both share one generated implementation
    logic              ren_p      [2];
    logic [ADDR-1:0]   raddr_p    [2];
    logic [W_SIZE-1:0] rdata_reg  [2];
    logic [W_SIZE-1:0] rdata_next [2];
    logic              rvld_reg   [2];

    assign ren_p[0]   = dffs_bus.dffs_ren_a;
    assign raddr_p[0] = dffs_bus.dffs_raddr_a;
    assign ren_p[1]   = dffs_bus.dffs_ren_b;
    assign raddr_p[1] = dffs_bus.dffs_raddr_b;

    for (gi = 0; gi < 2; gi++) begin : g_rport
        // Next read word: zero out of range, merged write data on same-address hit when write-first
        always_comb begin
            rdata_next[gi] = '0;
            if ({1'b0, raddr_p[gi]} < WORDS_L) begin
                if (WF && eff_we && (eff_addr == raddr_p[gi]))
                    rdata_next[gi] = merge_be(mem_word[raddr_p[gi]], eff_be, eff_data);
                else
                    rdata_next[gi] = mem_word[raddr_p[gi]];
            end
        end

        // Registered read data and one-cycle valid strobe; data holds when idle
        always_ff @(posedge dffs_clk or posedge dffs_rst) begin
            if (dffs_rst) begin
                rdata_reg[gi] <= '0;
                rvld_reg[gi]  <= 1'b0;
            end else begin
                rvld_reg[gi] <= ren_p[gi];
                if (ren_p[gi]) rdata_reg[gi] <= rdata_next[gi];
            end
        end
    end

    assign dffs_bus.dffs_busy    = busy;
    assign dffs_bus.dffs_werr    = werr_reg;
    assign dffs_bus.dffs_rdata_a = rdata_reg[0];
    assign dffs_bus.dffs_rvld_a  = rvld_reg[0];
    assign dffs_bus.dffs_rdata_b = rdata_reg[1];
    assign dffs_bus.dffs_rvld_b  = rvld_reg[1];
endmodule

// File: tb/tb_regs_dp_be_s.sv
// Bench for regs_dp_be_s: a write-first and a read-first instance share one
// stimulus stream and are checked every cycle against a word-array model.
module tb_regs_dp_be_s;
    localparam int          ADDR  = 6;
    localparam int          WORDS = 48;
    localparam int          W     = 32;
    localparam logic [31:0] CLRV  = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        clr, wen, ren_a, ren_b;
    logic [5:0]  waddr, raddr_a, raddr_b;
    logic [3:0]  wbe;
    logic [31:0] wdata;

    regs_dp_be_s_if #(.ADDR(ADDR), .W_SIZE(W)) bus_wf ();
    regs_dp_be_s_if #(.ADDR(ADDR), .W_SIZE(W)) bus_rf ();

    assign bus_wf.dffs_clr = clr;      assign bus_rf.dffs_clr = clr;
    assign bus_wf.dffs_wen = wen;      assign bus_rf.dffs_wen = wen;
    assign bus_wf.dffs_waddr = waddr;  assign bus_rf.dffs_waddr = waddr;
    assign bus_wf.dffs_wbe = wbe;      assign bus_rf.dffs_wbe = wbe;
    assign bus_wf.dffs_wdata = wdata;  assign bus_rf.dffs_wdata = wdata;
    assign bus_wf.dffs_ren_a = ren_a;  assign bus_rf.dffs_ren_a = ren_a;
    assign bus_wf.dffs_raddr_a = raddr_a; assign bus_rf.dffs_raddr_a = raddr_a;
    assign bus_wf.dffs_ren_b = ren_b;  assign bus_rf.dffs_ren_b = ren_b;
    assign bus_wf.dffs_raddr_b = raddr_b; assign bus_rf.dffs_raddr_b = raddr_b;

    regs_dp_be_s #(.ADDR(ADDR), .WORDS(WORDS), .W_SIZE(W), .BYPASS(1), .CLR_VAL(CLRV))
        u_dut_wf (.dffs_clk(clk), .dffs_rst(rst), .dffs_bus(bus_wf));
    regs_dp_be_s #(.ADDR(ADDR), .WORDS(WORDS), .W_SIZE(W), .BYPASS(0), .CLR_VAL(CLRV))
        u_dut_rf (.dffs_clk(clk), .dffs_rst(rst), .dffs_bus(bus_rf));

    // Reference model: plain word array plus "sweep in progress" bookkeeping
    logic [31:0] m_mem [WORDS];
    bit          m_active;
    int          m_idx;
    logic        exp_busy, exp_werr, exp_rvld_a, exp_rvld_b;
    logic [31:0] exp_a_wf, exp_a_rf, exp_b_wf, exp_b_rf;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
        m_active = 0; m_idx = 0;
        exp_busy = 0; exp_werr = 0; exp_rvld_a = 0; exp_rvld_b = 0;
        exp_a_wf = '0; exp_a_rf = '0; exp_b_wf = '0; exp_b_rf = '0;
    endtask

    task automatic compare_all();
        chk("busy_wf",  {31'b0, bus_wf.dffs_busy},   {31'b0, exp_busy});
        chk("busy_rf",  {31'b0, bus_rf.dffs_busy},   {31'b0, exp_busy});
        chk("werr_wf",  {31'b0, bus_wf.dffs_werr},   {31'b0, exp_werr});
        chk("werr_rf",  {31'b0, bus_rf.dffs_werr},   {31'b0, exp_werr});
        chk("rvld_a_wf", {31'b0, bus_wf.dffs_rvld_a}, {31'b0, exp_rvld_a});
        chk("rvld_a_rf", {31'b0, bus_rf.dffs_rvld_a}, {31'b0, exp_rvld_a});
        chk("rvld_b_wf", {31'b0, bus_wf.dffs_rvld_b}, {31'b0, exp_rvld_b});
        chk("rvld_b_rf", {31'b0, bus_rf.dffs_rvld_b}, {31'b0, exp_rvld_b});
        chk("rdata_a_wf", bus_wf.dffs_rdata_a, exp_a_wf);
        chk("rdata_a_rf", bus_rf.dffs_rdata_a, exp_a_rf);
        chk("rdata_b_wf", bus_wf.dffs_rdata_b, exp_b_wf);
        chk("rdata_b_rf", bus_rf.dffs_rdata_b, exp_b_rf);
    endtask

    // One clock: update the model from the inputs seen at the edge, compare on the falling edge
    task automatic tick();
        logic [31:0] nm [WORDS];
        @(posedge clk);
        nm = m_mem;
        exp_werr = wen && (m_active || (int'(waddr) >= WORDS));
        if (m_active) nm[m_idx] = CLRV;
        else if (wen && int'(waddr) < WORDS)
            for (int k = 0; k < 4; k++) if (wbe[k]) nm[waddr][8*k +: 8] = wdata[8*k +: 8];
        exp_rvld_a = ren_a;
        if (ren_a) begin
            if (int'(raddr_a) < WORDS) begin exp_a_wf = nm[raddr_a]; exp_a_rf = m_mem[raddr_a]; end
            else begin exp_a_wf = '0; exp_a_rf = '0; end
        end
        exp_rvld_b = ren_b;
        if (ren_b) begin
            if (int'(raddr_b) < WORDS) begin exp_b_wf = nm[raddr_b]; exp_b_rf = m_mem[raddr_b]; end
            else begin exp_b_wf = '0; exp_b_rf = '0; end
        end
        if (m_active) begin
            m_idx++;
            if (m_idx == WORDS) begin m_active = 0; m_idx = 0; end
        end else if (clr) begin
            m_active = 1; m_idx = 0;
        end
        m_mem = nm;
        exp_busy = m_active;
        @(negedge clk);
        compare_all();
        $display("cyc t=%0t wen=%b wa=%0d ra=%0d rb=%0d busy=%b rda=%h rdb=%h",
                 $time, wen, waddr, raddr_a, raddr_b, bus_wf.dffs_busy,
                 bus_wf.dffs_rdata_a, bus_wf.dffs_rdata_b);
        clr = 0; wen = 0; ren_a = 0; ren_b = 0;
    endtask

    task automatic scan_expect(input logic [31:0] val);
        for (int i = 0; i < WORDS; i++) begin
            ren_a = 1; raddr_a = 6'(i);
            ren_b = 1; raddr_b = 6'(WORDS - 1 - i);
            tick();
            chk("scan_a", bus_wf.dffs_rdata_a, val);
            chk("scan_b", bus_rf.dffs_rdata_b, val);
        end
    endtask

    int cnt, guard, na, nb;

    initial begin
        clr = 0; wen = 0; ren_a = 0; ren_b = 0;
        waddr = '0; raddr_a = '0; raddr_b = '0; wbe = '0; wdata = '0;
        rst = 1;
        model_reset();
        #1;
        compare_all();
        #11 rst = 0;

        // Full-word write then read
        wen = 1; waddr = 5; wbe = 4'hF; wdata = 32'hA5A5_1234; tick();
        ren_a = 1; raddr_a = 5; tick();
        chk("t1_model", exp_a_wf, 32'hA5A5_1234);
        chk("t1_rdata", bus_wf.dffs_rdata_a, 32'hA5A5_1234);
        chk("t1_rvld", {31'b0, bus_wf.dffs_rvld_a}, 32'd1);
        tick();
        chk("t1_rvld_drop", {31'b0, bus_wf.dffs_rvld_a}, 32'd0);

        // Byte-enabled write colliding with a read
        wen = 1; waddr = 5; wbe = 4'hF; wdata = 32'h1122_3344; tick();
        wen = 1; waddr = 5; wbe = 4'b0101; wdata = 32'hAABB_CCDD; ren_a = 1; raddr_a = 5; tick();
        chk("t2_model_wf", exp_a_wf, 32'h11BB_33DD);
        chk("t2_model_rf", exp_a_rf, 32'h1122_3344);
        chk("t2_wf", bus_wf.dffs_rdata_a, 32'h11BB_33DD);
        chk("t2_rf", bus_rf.dffs_rdata_a, 32'h1122_3344);
        ren_a = 1; raddr_a = 5; tick();
        chk("t2_after_rf", bus_rf.dffs_rdata_a, 32'h11BB_33DD);

        // Back-to-back reads on both ports, out-of-range reads
        wen = 1; waddr = 3; wbe = 4'hF; wdata = 32'h3333_0003; tick();
        na = 0; nb = 0;
        for (int i = 0; i < 4; i++) begin
            ren_a = 1; raddr_a = 3; ren_b = 1; raddr_b = 63; tick();
            if (bus_wf.dffs_rvld_a) na++;
            if (bus_wf.dffs_rvld_b) nb++;
            chk("t3_a", bus_wf.dffs_rdata_a, 32'h3333_0003);
            chk("t3_b_oor", bus_wf.dffs_rdata_b, 32'h0);
        end
        chk("t3_rvld_a_cnt", na, 4);
        chk("t3_rvld_b_cnt", nb, 4);
        ren_a = 1; raddr_a = 50; tick();
        chk("t3_oor_data", bus_wf.dffs_rdata_a, 32'h0);
        chk("t3_oor_vld", {31'b0, bus_wf.dffs_rvld_a}, 32'd1);

        // Out-of-range write is dropped and flagged for exactly one cycle
        wen = 1; waddr = 60; wbe = 4'hF; wdata = 32'hFFFF_FFFF; tick();
        chk("t6_werr", {31'b0, bus_wf.dffs_werr}, 32'd1);
        tick();
        chk("t6_werr_drop", {31'b0, bus_wf.dffs_werr}, 32'd0);
        scan_expect_model: for (int i = 0; i < WORDS; i++) begin
            ren_a = 1; raddr_a = 6'(i); tick();
        end

        // Clear sweep with a rejected write in the middle
        clr = 1; tick();
        cnt = 0;
        while (bus_wf.dffs_busy && cnt < 200) begin
            cnt++;
            if (cnt == 10) begin wen = 1; waddr = 2; wbe = 4'hF; wdata = 32'h1234_5678; end
            if (cnt == 15) clr = 1;
            tick();
            if (cnt == 10) chk("t4_werr", {31'b0, bus_wf.dffs_werr}, 32'd1);
        end
        chk("t4_busy_cycles", cnt, WORDS);
        scan_expect(CLRV);

        // Asynchronous reset mid-sweep
        clr = 1; tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 19) begin ren_a = 1; raddr_a = 0; end
            tick();
        end
        chk("t5_pre_rdata", bus_wf.dffs_rdata_a, CLRV);
        #1 rst = 1;
        #1;
        model_reset();
        chk("t5_busy", {31'b0, bus_wf.dffs_busy}, 32'd0);
        chk("t5_rvld", {31'b0, bus_wf.dffs_rvld_a}, 32'd0);
        chk("t5_rdata", bus_wf.dffs_rdata_a, 32'h0);
        chk("t5_rdata_rf", bus_rf.dffs_rdata_a, 32'h0);
        #1 rst = 0;
        scan_expect(32'h0);
        clr = 1; tick();
        cnt = 0;
        while (bus_wf.dffs_busy && cnt < 200) begin cnt++; tick(); end
        chk("t5_resweep", cnt, WORDS);

        // Randomized traffic with frequent address collisions
        for (int n = 0; n < 3000; n++) begin
            wen   = ($urandom_range(0, 1) == 1);
            waddr = 6'($urandom_range(0, 63));
            wbe   = 4'($urandom);
            wdata = $urandom;
            ren_a = ($urandom_range(0, 9) < 6);
            raddr_a = ($urandom_range(0, 9) < 3) ? waddr : 6'($urandom_range(0, 63));
            ren_b = ($urandom_range(0, 9) < 6);
            raddr_b = ($urandom_range(0, 9) < 3) ? waddr : 6'($urandom_range(0, 63));
            clr   = ($urandom_range(0, 199) == 0);
            tick();
        end
        guard = 0;
        while (bus_wf.dffs_busy && guard < 200) begin guard++; tick(); end
        chk("final_idle", {31'b0, bus_wf.dffs_busy}, 32'd0);
        for (int i = 0; i < WORDS; i++) begin
            ren_a = 1; raddr_a = 6'(i); ren_b = 1; raddr_b = 6'(i); tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
